// File: rtl/adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
// adc_sample_scheduler : round-robin shared ADC access with sample averaging
// Rev 1.0
// ============================================================================
module adc_sample_scheduler #(
   parameter int N_REQ    = 4,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 1000
) (
   input  logic                 sys_clk,
   input  logic                 reset_n,
   input  logic [255:0]         adc_channels,
   input  logic                 sample_tick,
   input  logic [N_REQ-1:0]     req,
   input  logic [3*N_REQ-1:0]   req_chan,
   output logic [N_REQ-1:0]     ack,
   output logic                 err,
   output logic [11:0]          rd_data,
   output logic [2:0]           grant_id,
   output logic                 busy
);

   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int TO_W  = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [2:0]         rr_ptr;
   logic [2:0]         chan;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [TO_W-1:0]    to_cnt;

   logic [7:0]         req_pad;
   logic [2:0]         chan_of [8];
   logic [11:0]        field   [8];
   logic [ACC_W-1:0]   acc_sum;
   logic               found;
   logic [2:0]         pick;
   logic               unused_bits;

   assign req_pad     = 8'(req);
   assign unused_bits = ^adc_channels;

   for (genvar i = 0; i < 8; i++) begin : g_lanes
      assign field[i] = adc_channels[32*i +: 12];
      if (i < N_REQ) begin : g_used
         assign chan_of[i] = req_chan[3*i +: 3];
      end else begin : g_pad
         assign chan_of[i] = 3'd0;
      end
   end

   assign acc_sum = acc + ACC_W'(field[chan]);

   // First set request strictly after the last winner, wrapping at N_REQ.
   always_comb begin
      logic [3:0] idx;
      found = 1'b0;
      pick  = 3'd0;
      idx   = 4'd0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, rr_ptr} + 4'd1 + 4'(k);
         if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
         if (!found && req_pad[idx[2:0]]) begin
            found = 1'b1;
            pick  = idx[2:0];
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         ack      <= '0;
         err      <= 1'b0;
         rd_data  <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
         rr_ptr   <= 3'(N_REQ - 1);
         chan     <= '0;
         acc      <= '0;
         cnt      <= '0;
         to_cnt   <= '0;
      end else begin
         ack <= '0;
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant_id <= pick;
                  rr_ptr   <= pick;
                  chan     <= chan_of[pick];
                  acc      <= '0;
                  cnt      <= '0;
                  to_cnt   <= '0;
                  busy     <= 1'b1;
                  state    <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               // Timeout wins over a simultaneous request drop.
               if (!sample_tick && to_cnt == TO_LAST) begin
                  ack     <= N_REQ'(1) << grant_id;
                  err     <= 1'b1;
                  rd_data <= 12'(acc >> AVG_LOG2);
                  state   <= S_DONE;
               end else if (!req_pad[grant_id]) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (sample_tick) begin
                  acc    <= acc_sum;
                  cnt    <= cnt + 1'b1;
                  to_cnt <= '0;
                  if (cnt == LAST_CNT) begin
                     ack     <= N_REQ'(1) << grant_id;
                     rd_data <= 12'(acc_sum >> AVG_LOG2);
                     state   <= S_DONE;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
// tb_adc_sample_scheduler : directed + randomized checks against a reference
// Rev 1.0
// ============================================================================
module tb_adc_sample_scheduler;

   localparam int N_REQ    = 4;
   localparam int AVG_LOG2 = 2;
   localparam int TIMEOUT  = 20;
   localparam int NS       = 1 << AVG_LOG2;

   logic                sys_clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [255:0]        adc_channels = '0;
   logic                sample_tick = 1'b0;
   logic [N_REQ-1:0]    req = '0;
   logic [3*N_REQ-1:0]  req_chan = '0;

   logic [N_REQ-1:0]    ack, ack0;
   logic                err, err0;
   logic [11:0]         rd_data, rd0;
   logic [2:0]          grant_id, gid0;
   logic                busy, busy0;

   int total = 0;
   int bad   = 0;
   int model_rr;
   logic [11:0] model_rd;

   always #5 sys_clk = ~sys_clk;

   adc_sample_scheduler #(.N_REQ(N_REQ), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) u_dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .adc_channels(adc_channels),
      .sample_tick(sample_tick), .req(req), .req_chan(req_chan),
      .ack(ack), .err(err), .rd_data(rd_data), .grant_id(grant_id), .busy(busy));

   adc_sample_scheduler #(.N_REQ(N_REQ), .AVG_LOG2(0), .TIMEOUT(TIMEOUT)) u_dut0 (
      .sys_clk(sys_clk), .reset_n(reset_n), .adc_channels(adc_channels),
      .sample_tick(sample_tick), .req(req), .req_chan(req_chan),
      .ack(ack0), .err(err0), .rd_data(rd0), .grant_id(gid0), .busy(busy0));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_tick(input logic [255:0] bus);
      adc_channels = bus;
      sample_tick  = 1'b1;
      step();
      sample_tick  = 1'b0;
   endtask

   function automatic logic [255:0] rand_bus(input int c, input logic [11:0] v);
      logic [255:0] b;
      for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
      b = (b & ~(256'hFFF << (32*c))) | (256'(v) << (32*c));
      return b;
   endfunction

   // Round-robin rule: first requester after the last winner, cyclically.
   function automatic int rr_pick(input logic [N_REQ-1:0] m, input int last);
      for (int k = 1; k <= N_REQ; k++)
         if (((m >> ((last + k) % N_REQ)) & N_REQ'(1)) != '0) return (last + k) % N_REQ;
      return -1;
   endfunction

   task automatic do_reset();
      reset_n = 1'b0; req = '0; sample_tick = 1'b0;
      step(); step();
      reset_n  = 1'b1;
      model_rr = N_REQ - 1;
      model_rd = '0;
   endtask

   task automatic run_op(input logic [N_REQ-1:0] mask, input logic [3*N_REQ-1:0] chans,
                         input int max_gap, input string tag);
      int g, c, sum;
      logic [11:0] v;
      logic [N_REQ-1:0] e;
      req = mask; req_chan = chans;
      g = rr_pick(mask, model_rr);
      c = int'((chans >> (3*g)) & 12'h7);
      step();
      check($sformatf("%s grant", tag), 32'(grant_id), g);
      check($sformatf("%s busy_on", tag), 32'(busy), 1);
      sum = 0;
      for (int i = 0; i < NS; i++) begin
         repeat ($urandom_range(max_gap, 0)) step();
         v = 12'($urandom);
         sum += int'(v);
         do_tick(rand_bus(c, v));
         if (i < NS - 1) check($sformatf("%s early_ack", tag), 32'(ack), 0);
      end
      model_rr = g;
      model_rd = 12'(sum >> AVG_LOG2);
      e = N_REQ'(1) << g;
      check($sformatf("%s ack", tag), 32'(ack), 32'(e));
      check($sformatf("%s rd", tag), 32'(rd_data), 32'(model_rd));
      check($sformatf("%s err", tag), 32'(err), 0);
      step();
      check($sformatf("%s busy_off", tag), 32'(busy), 0);
      check($sformatf("%s ack_off", tag), 32'(ack), 0);
   endtask

   initial begin
      int n;
      logic got;
      logic [11:0] vals [4];
      logic [3*N_REQ-1:0] chans;

      // Reset values
      do_reset();
      check("rst ack", 32'(ack), 0);
      check("rst err", 32'(err), 0);
      check("rst rd", 32'(rd_data), 0);
      check("rst gid", 32'(grant_id), 0);
      check("rst busy", 32'(busy), 0);

      // Single request, channel 3, 100..112 averages to 106
      vals = '{12'd100, 12'd104, 12'd108, 12'd112};
      req = 4'b0001; req_chan = 12'd3;
      step();
      check("single busy", 32'(busy), 1);
      model_rr = 0;
      for (int i = 0; i < 4; i++) begin
         do_tick(rand_bus(3, vals[i]));
         if (i < 3) check("single early_ack", 32'(ack), 0);
      end
      check("single ack", 32'(ack), 32'h1);
      check("single rd", 32'(rd_data), 106);
      check("single err", 32'(err), 0);
      check("single gid", 32'(grant_id), 0);
      req = '0;
      step();
      check("single idle", 32'(busy), 0);

      // Stale tick coincident with grant edge (single-sample instance)
      do_reset();
      req = 4'b0001; req_chan = 12'd2;
      adc_channels = rand_bus(2, 12'h123); sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      check("stale no_ack", 32'(ack0), 0);
      check("stale busy", 32'(busy0), 1);
      do_tick(rand_bus(2, 12'h7FF));
      check("stale ack", 32'(ack0), 32'h1);
      check("stale rd", 32'(rd0), 32'h7FF);
      check("stale err", 32'(err0), 0);

      // Round robin with all requests held
      do_reset();
      chans = 12'($urandom);
      for (int k = 0; k < 5; k++) run_op(4'b1111, chans, 0, $sformatf("rr%0d", k));

      // Channel extraction, garbage in upper bits of every field
      for (int c = 0; c < 8; c++) run_op(4'b0010, 12'(c << 3), 1, $sformatf("chan%0d", c));
      req = '0;
      step();

      // Timeout after one sample of 400
      req = 4'b0001; req_chan = 12'd0;
      step();
      check("to gid", 32'(grant_id), 0);
      model_rr = 0;
      do_tick(rand_bus(0, 12'd400));
      n = 0; got = 1'b0;
      while (!got && n < TIMEOUT + 5) begin
         step();
         n++;
         if (ack != '0) got = 1'b1;
      end
      check("to latency", n, TIMEOUT);
      check("to ack", 32'(ack), 32'h1);
      check("to err", 32'(err), 1);
      check("to rd", 32'(rd_data), 100);
      model_rd = 12'd100;
      req = '0;
      step();

      // Abort: requester 1 drops after two ticks
      req = 4'b0010; req_chan = 12'(5 << 3);
      step();
      check("abort gid", 32'(grant_id), 1);
      model_rr = 1;
      do_tick(rand_bus(5, 12'($urandom)));
      do_tick(rand_bus(5, 12'($urandom)));
      req = '0;
      step();
      check("abort busy", 32'(busy), 0);
      check("abort ack", 32'(ack), 0);
      check("abort rd", 32'(rd_data), 32'(model_rd));
      step(); step();
      check("abort late_ack", 32'(ack), 0);

      // Randomized operations
      for (int k = 0; k < 20; k++)
         run_op(N_REQ'($urandom_range((1 << N_REQ) - 1, 1)), 12'($urandom), 3,
                $sformatf("rnd%0d", k));

      // Reset mid-accumulation
      req = 4'b0001; req_chan = 12'd0;
      step();
      do_tick(rand_bus(0, 12'hABC));
      reset_n = 1'b0;
      step();
      check("midrst ack", 32'(ack), 0);
      check("midrst err", 32'(err), 0);
      check("midrst rd", 32'(rd_data), 0);
      check("midrst gid", 32'(grant_id), 0);
      check("midrst busy", 32'(busy), 0);
      reset_n = 1'b1; req = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
